sync_fifo: RTL and testbench

Synchronous first-word-fall-through FIFO with fill-level reporting.
Used in AXI4-lite width converters to queue per-request side information, such as sub-word address lanes, between request acceptance and response return.
One clock domain; the write and read ports operate in the same cycle without interference.

---
 rtl/sync_fifo.sv | 101 ++++++++++
 tb/tb_sync_fifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//
// Synchronous first-word-fall-through FIFO with fill-level reporting. Holds
// per-request side information (e.g. sub-word address lanes) between request
// acceptance and response return in AXI4-lite width converters.
//
// Parameters:
//   BW      - data word width in bits (>=1)
//   LGFLEN  - log2 of FIFO depth; depth = 2^LGFLEN entries (>=1)
//
// Ports:
//   i_clk    in   1         clock, all state updates on rising edge
//   i_reset  in   1         asynchronous, active-high reset
//   i_wr     in   1         write request
//   i_data   in   BW        write data
//   o_full   out  1         FIFO holds 2^LGFLEN entries
//   o_fill   out  LGFLEN+1  current entry count, 0..2^LGFLEN
//   i_rd     in   1         read/pop request
//   o_data   out  BW        head entry (first-word-fall-through)
//   o_empty  out  1         FIFO holds 0 entries
//
// Build option:
//   SYNC_FIFO_WRITE_ON_FULL_EN - when defined, a write presented while full
//   is accepted if a pop happens in the same cycle (the freed slot is reused).
//   When undefined, any write while full is dropped.
//
// Handshake: a write transfers on a rising edge when i_wr is high and the
// FIFO can take it (!o_full, or a same-cycle pop with the build option); a
// read transfers when i_rd is high and !o_empty. o_data is the head entry
// and is meaningful only while !o_empty. Requests that cannot transfer are
// silently dropped; the requester must watch o_full / o_empty.
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int BW     = 8,
    parameter int LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr,
    input  logic [BW-1:0]     i_data,
    output logic              o_full,
    output logic [LGFLEN:0]   o_fill,
    input  logic              i_rd,
    output logic [BW-1:0]     o_data,
    output logic              o_empty
);

    localparam logic [LGFLEN:0] PTR_ONE = (LGFLEN+1)'(1);
    localparam logic [LGFLEN:0] DEPTH   = {1'b1, {LGFLEN{1'b0}}};

    // Pointers carry one extra bit so that full (difference == DEPTH) and
    // empty (difference == 0) are distinguishable without a separate flag.
    logic [LGFLEN:0] wr_ptr;
    logic [LGFLEN:0] rd_ptr;
    logic [BW-1:0]   mem [0:(1<<LGFLEN)-1];

    logic w_ok;
    logic r_ok;

`ifdef SYNC_FIFO_WRITE_ON_FULL_EN
    // While full, a same-cycle pop frees the head slot, which is the very
    // slot the write pointer addresses; the head is read out combinationally
    // before the edge, so reusing it is safe.
    assign w_ok = i_wr && (!o_full || i_rd);
`else
    assign w_ok = i_wr && !o_full;
`endif

    assign r_ok = i_rd && !o_empty;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (w_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (r_ok)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage is intentionally not reset; stale contents are never visible
    // because o_data is don't-care while empty.
    always_ff @(posedge i_clk) begin
        if (w_ok)
            mem[wr_ptr[LGFLEN-1:0]] <= i_data;
    end

    // Fill and both flags are derived from the registered pointers, so they
    // agree in every cycle and follow reset asynchronously.
    assign o_fill  = wr_ptr - rd_ptr;
    assign o_empty = (o_fill == '0);
    assign o_full  = (o_fill == DEPTH);

    // No write-to-read bypass: a word written into an empty FIFO shows up
    // here the cycle after the write.
    assign o_data  = mem[rd_ptr[LGFLEN-1:0]];

endmodule

// File: tb/tb_sync_fifo.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo
//
// Self-checking bench for sync_fifo (BW=2, LGFLEN=5). A queue-based reference
// model tracks the expected contents; every cycle the DUT's fill, flags and
// head word are compared against it.
// ----------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int BW     = 2;
    localparam int LGFLEN = 5;
    localparam int DEPTH  = 1 << LGFLEN;

`ifdef SYNC_FIFO_WRITE_ON_FULL_EN
    localparam bit WOF = 1'b1;
`else
    localparam bit WOF = 1'b0;
`endif

    logic              i_clk;
    logic              i_reset;
    logic              i_wr;
    logic [BW-1:0]     i_data;
    logic              o_full;
    logic [LGFLEN:0]   o_fill;
    logic              i_rd;
    logic [BW-1:0]     o_data;
    logic              o_empty;

    int total;
    int bad;

    logic [BW-1:0] exp_q[$];

    sync_fifo #(.BW(BW), .LGFLEN(LGFLEN)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_wr    (i_wr),
        .i_data  (i_data),
        .o_full  (o_full),
        .o_fill  (o_fill),
        .i_rd    (i_rd),
        .o_data  (o_data),
        .o_empty (o_empty)
    );

    // ------------------------------------------------------------ clock/reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ------------------------------------------------------------ checking
    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Compare every observable output against the model's queue.
    task automatic check_state(input string tag);
        check_val({tag, ".fill"},  32'(o_fill),  32'(exp_q.size()));
        check_val({tag, ".empty"}, 32'(o_empty), 32'(exp_q.size() == 0));
        check_val({tag, ".full"},  32'(o_full),  32'(exp_q.size() == DEPTH));
        if (exp_q.size() != 0)
            check_val({tag, ".data"}, 32'(o_data), 32'(exp_q[0]));
    endtask

    // ------------------------------------------------------------ driver
    // Called at a falling edge: drives one cycle of requests, applies the
    // model's view of what was accepted at the rising edge, and checks the
    // outputs at the following falling edge.
    task automatic step(input logic wr, input logic rd, input logic [BW-1:0] d,
                        input string tag);
        bit rd_acc;
        bit wr_acc;
        i_wr   = wr;
        i_rd   = rd;
        i_data = d;
        rd_acc = rd && (exp_q.size() > 0);
        wr_acc = wr && ((exp_q.size() < DEPTH) || (WOF && rd));
        @(posedge i_clk);
        if (rd_acc) void'(exp_q.pop_front());
        if (wr_acc) exp_q.push_back(d);
        @(negedge i_clk);
        i_wr = 1'b0;
        i_rd = 1'b0;
        check_state(tag);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [BW-1:0] pat;
        logic [BW-1:0] newest;
        total   = 0;
        bad     = 0;
        i_wr    = 1'b0;
        i_rd    = 1'b0;
        i_data  = '0;
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);

        // 1. reset state, then the first write
        check_val("rst.fill",  32'(o_fill),  32'd0);
        check_val("rst.empty", 32'(o_empty), 32'd1);
        check_val("rst.full",  32'(o_full),  32'd0);
        i_reset = 1'b0;
        @(negedge i_clk);
        step(1'b1, 1'b0, 2'b10, "first_wr");
        check_val("first_wr.data_const", 32'(o_data), 32'd2);
        step(1'b0, 1'b1, 2'b00, "first_rd");

        // 2. fill to depth, overflow write alone, drain
        for (int i = 0; i < DEPTH; i++) begin
            pat = BW'(i);
            step(1'b1, 1'b0, pat, "fill");
        end
        check_val("fill.full_const", 32'(o_full), 32'd1);
        check_val("fill.fill_const", 32'(o_fill), 32'(DEPTH));
        step(1'b1, 1'b0, 2'b11, "overflow");
        for (int i = 0; i < DEPTH; i++) begin
            pat = BW'(i);
            check_val("drain.seq", 32'(o_data), 32'(pat));
            step(1'b0, 1'b1, 2'b00, "drain");
        end
        check_val("drain.empty_const", 32'(o_empty), 32'd1);

        // 3. simultaneous read/write at fill=5 across pointer wrap
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, BW'($urandom_range(0, 3)), "pre5");
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'b1, BW'($urandom_range(0, 3)), "rw5");
        check_val("rw5.fill_const", 32'(o_fill), 32'd5);
        while (exp_q.size() != 0)
            step(1'b0, 1'b1, 2'b00, "rw5_drain");

        // 4. read+write on empty: only the write lands
        step(1'b1, 1'b1, 2'd3, "rw_empty");
        check_val("rw_empty.fill_const", 32'(o_fill), 32'd1);
        check_val("rw_empty.data_const", 32'(o_data), 32'd3);
        step(1'b0, 1'b1, 2'b00, "rw_empty_rd");

        // 5. read+write while full
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, BW'($urandom_range(0, 3)), "fill2");
        newest = BW'(~exp_q[DEPTH-1]);
        step(1'b1, 1'b1, newest, "full_rw");
        check_val("full_rw.fill_const", 32'(o_fill), WOF ? 32'(DEPTH) : 32'(DEPTH-1));
        check_val("full_rw.full_const", 32'(o_full), WOF ? 32'd1 : 32'd0);
        while (exp_q.size() > 1)
            step(1'b0, 1'b1, 2'b00, "full_rw_drain");
        check_val("full_rw.last", 32'(o_data), WOF ? 32'(newest) : 32'(exp_q[0]));
        step(1'b0, 1'b1, 2'b00, "full_rw_drain");

        // 6. asynchronous reset mid-stream at fill=17
        for (int i = 0; i < 17; i++)
            step(1'b1, 1'b0, BW'($urandom_range(0, 3)), "fill17");
        check_val("pre_rst.fill", 32'(o_fill), 32'd17);
        #2;
        i_reset = 1'b1;
        #1;
        exp_q.delete();
        check_val("async_rst.fill",  32'(o_fill),  32'd0);
        check_val("async_rst.empty", 32'(o_empty), 32'd1);
        check_val("async_rst.full",  32'(o_full),  32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        step(1'b1, 1'b0, 2'd1, "post_rst_wr");
        check_val("post_rst.data_const", 32'(o_data), 32'd1);
        step(1'b0, 1'b1, 2'b00, "post_rst_rd");

        // 7. random traffic against the model
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 BW'($urandom_range(0, 3)), "rand");
        // bias towards full, then towards empty
        for (int i = 0; i < 150; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 BW'($urandom_range(0, 3)), "rand_hi");
        for (int i = 0; i < 150; i++)
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
                 BW'($urandom_range(0, 3)), "rand_lo");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
